rca16_operand_stage: RTL and testbench

- Sequential front/back stage for the 16-bit ripple-carry adder netlist.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the adder's add1/add2 inputs and registers the adder's 17-bit result into an output holding register with its own valid/ready handshake.
- The adder instance stays external so obfuscated and plain netlists can be swapped without touching this block.

---
 rtl/rca16_operand_stage.sv | 117 +++++++++++
 tb/tb_rca16_operand_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca16_operand_stage.sv
// Operand FIFO and result holding register around an external 16-bit ripple-carry adder.
// Operand pairs queue in the FIFO; the head drives the adder and its 17-bit result is captured downstream.
module rca16_operand_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [15:0]              a_i,
  input  logic [15:0]              b_i,
  output logic [15:0]              add1_o,
  output logic [15:0]              add2_o,
  input  logic [16:0]              sum_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [16:0]              sum_o,
  output logic                     carry_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  logic [DATA_W-1:0] mem_a_p0 [DEPTH];
  logic [DATA_W-1:0] mem_b_p0 [DEPTH];
  logic [AW-1:0]     wr_ptr_p0;
  logic [AW-1:0]     rd_ptr_p0;
  logic [LW-1:0]     level_p0;

  logic              vld_p1;
  logic [16:0]       sum_p1;
  logic              carry_p1;
  logic [CNT_W-1:0]  count_p1;

  logic              empty;
  logic              full;
  logic              push;
  logic              capture;
  logic              out_hs;

  assign empty   = (level_p0 == '0);
  assign full    = (level_p0 == LW'(DEPTH));
  // Gated by rst_ni so nothing is accepted while reset is asserted; no bypass when full.
  assign in_ready_o = rst_ni && !full;
  assign push    = in_valid_i && in_ready_o;
  assign capture = !empty && (!vld_p1 || out_ready_i);
  assign out_hs  = vld_p1 && out_ready_i;

  // ---- stage p0: operand FIFO ----
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_p0[wr_ptr_p0] <= a_i;
      mem_b_p0[wr_ptr_p0] <= b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      level_p0  <= '0;
    end else begin
      if (push)
        wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
      if (capture)
        rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
      case ({push, capture})
        2'b10:   level_p0 <= level_p0 + LW'(1);
        2'b01:   level_p0 <= level_p0 - LW'(1);
        default: level_p0 <= level_p0;
      endcase
    end
  end

  // Head is read straight from storage, so a_i/b_i never glitch the adder inputs.
  assign add1_o  = empty ? '0 : mem_a_p0[rd_ptr_p0];
  assign add2_o  = empty ? '0 : mem_b_p0[rd_ptr_p0];
  assign level_o = level_p0;

  // ---- stage p1: result holding register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
      count_p1 <= '0;
    end else begin
      if (capture) begin
        vld_p1   <= 1'b1;
        sum_p1   <= sum_i;
        carry_p1 <= sum_i[16];
      end else if (out_hs) begin
        vld_p1   <= 1'b0;
      end
      if (out_hs)
        count_p1 <= sat_inc(count_p1);
    end
  end

  assign out_valid_o = vld_p1;
  assign sum_o       = sum_p1;
  assign carry_o     = carry_p1;
  assign count_o     = count_p1;

endmodule

// File: tb/tb_rca16_operand_stage.sv
// Directed bench for rca16_operand_stage; the bench models the external adder on add1_o/add2_o.
module tb_rca16_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, carry;
  logic [15:0] a, b, add1, add2;
  logic [16:0] sum_in, sum_out;
  logic [15:0] count;
  logic [2:0]  level;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_carry;
  logic [15:0] s_a, s_b, s_add1, s_add2;
  logic [16:0] s_sum_in, s_sum_out;
  logic [3:0]  s_count;
  logic [2:0]  s_level;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ea [100];
  logic [15:0] eb [100];
  logic [16:0] exp_sum;

  always #5 clk = ~clk;

  assign sum_in   = {1'b0, add1} + {1'b0, add2};
  assign s_sum_in = {1'b0, s_add1} + {1'b0, s_add2};

  rca16_operand_stage #(.DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .add1_o(add1), .add2_o(add2), .sum_i(sum_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum_out),
    .carry_o(carry), .count_o(count), .level_o(level)
  );

  rca16_operand_stage #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .a_i(s_a), .b_i(s_b), .add1_o(s_add1), .add2_o(s_add2), .sum_i(s_sum_in),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .sum_o(s_sum_out),
    .carry_o(s_carry), .count_o(s_count), .level_o(s_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = 16'h0003; s_b = 16'h0004;
    step(); step();
    // reset state
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_level", {29'b0, level}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {15'b0, sum_out}, 32'd0);
    chk("rst_carry", {31'b0, carry}, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    chk("rst_add1", {16'b0, add1}, 32'd0);
    chk("rst_sat_count", {28'b0, s_count}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // single op
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_add1", {16'b0, add1}, 32'd1);
    chk("single_add2", {16'b0, add2}, 32'd1);
    chk("single_level", {29'b0, level}, 32'd1);
    chk("single_not_valid_yet", {31'b0, out_valid}, 32'd0);
    step();
    chk("single_valid", {31'b0, out_valid}, 32'd1);
    chk("single_sum", {15'b0, sum_out}, 32'h00002);
    chk("single_carry", {31'b0, carry}, 32'd0);
    chk("single_level_empty", {29'b0, level}, 32'd0);
    step();
    chk("single_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("single_count", {16'b0, count}, 32'd1);

    // carry-out
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001;
    step();
    a = 16'hFFFF; b = 16'hFFFF;
    chk("carry_add1", {16'b0, add1}, 32'hFFFF);
    chk("carry_add2", {16'b0, add2}, 32'h0001);
    step();
    in_valid = 1'b0;
    chk("carry_sum1", {15'b0, sum_out}, 32'h10000);
    chk("carry_c1", {31'b0, carry}, 32'd1);
    step();
    chk("carry_sum2", {15'b0, sum_out}, 32'h1FFFE);
    chk("carry_c2", {31'b0, carry}, 32'd1);
    chk("carry_count2", {16'b0, count}, 32'd2);
    step();
    chk("carry_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("carry_count3", {16'b0, count}, 32'd3);

    // backpressure and full: pairs k give sums 0x11,0x22,0x33,0x44,0x55
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 16'h0010 * 16'(k + 1);
      b = 16'(k + 1);
      step();
      if (k >= 1) chk("bp_hold_sum", {15'b0, sum_out}, 32'h11);
    end
    chk("bp_level_full", {29'b0, level}, 32'd4);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    a = 16'h0060; b = 16'h0006;
    step();
    chk("bp_full_no_push", {29'b0, level}, 32'd4);
    chk("bp_sum_stable", {15'b0, sum_out}, 32'h11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("bp_drain_sum", {15'b0, sum_out}, 32'h11 * (k + 1));
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_drain_level", {29'b0, level}, 32'(4 - k));
      if (k == 1) chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
    end
    step();
    chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("bp_count", {16'b0, count}, 32'd8);

    // streaming with both sides held high
    for (int i = 0; i < 100; i++) begin
      ea[i] = 16'($urandom);
      eb[i] = 16'($urandom);
    end
    ea[0] = 16'hFFFF; eb[0] = 16'hFFFF;
    ea[1] = 16'h0000; eb[1] = 16'h0000;
    ea[2] = 16'h8000; eb[2] = 16'h8000;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; a = ea[i]; b = eb[i];
      step();
      if (i >= 1) begin
        exp_sum = {1'b0, ea[i-1]} + {1'b0, eb[i-1]};
        chk("stream_sum", {15'b0, sum_out}, {15'b0, exp_sum});
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
      end
    end
    in_valid = 1'b0;
    step();
    exp_sum = {1'b0, ea[99]} + {1'b0, eb[99]};
    chk("stream_last_sum", {15'b0, sum_out}, {15'b0, exp_sum});
    chk("stream_last_carry", {31'b0, carry}, {31'b0, exp_sum[16]});
    step();
    chk("stream_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("stream_count", {16'b0, count}, 32'd108);

    // async reset mid-stream with level 3 and a held result
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; a = 16'hAAAA; b = 16'(k);
      step();
    end
    in_valid = 1'b0;
    chk("arst_pre_level", {29'b0, level}, 32'd3);
    chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_level", {29'b0, level}, 32'd0);
    chk("arst_count", {16'b0, count}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("arst_sum", {15'b0, sum_out}, 32'd0);
    chk("arst_add1", {16'b0, add1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_rel_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_rel_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("arst_new_add1", {16'b0, add1}, 32'h1234);
    chk("arst_new_add2", {16'b0, add2}, 32'h4321);
    chk("arst_new_level", {29'b0, level}, 32'd1);
    step();
    chk("arst_new_sum", {15'b0, sum_out}, 32'h05555);
    chk("arst_new_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("arst_new_count", {16'b0, count}, 32'd1);
    chk("arst_new_drop", {31'b0, out_valid}, 32'd0);

    // counter saturation on the 4-bit instance
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 2) chk("sat_sum", {15'b0, s_sum_out}, 32'h7);
      if (c == 10) chk("sat_count_mid", {28'b0, s_count}, 32'd8);
      if (c == 17) chk("sat_count_reach", {28'b0, s_count}, 32'hF);
    end
    chk("sat_count_hold", {28'b0, s_count}, 32'hF);
    s_in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
